sub_serial_1c: RTL and testbench

Bit-serial subtractor computing A − B − Bin one bit per clock, least-significant bit first, with a start/busy/done handshake. It is the inverse-direction companion to the team's combinational ripple-carry adder. It is used where the subtraction path is latency-tolerant and area must be a single full-subtractor cell plus shift registers. Results are held stable after completion until the next accepted start.

---
 rtl/sub_serial_1c.sv | 126 ++++++++++++
 tb/tb_sub_serial_1c.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_1c.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first,
// with a start/busy/done handshake. Define SUB_SERIAL_OVF_EN to enable the signed overflow flag.
module sub_serial_1c #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] work_next;
  logic             last_bit;
  logic             accept;

  // Single full-subtractor cell operating on the current LSBs.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    d         = a_sh[0] ^ b_sh[0] ^ br;
    br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    work_next = {d, work[WIDTH-1:1]};
    last_bit  = (cnt == CW'(WIDTH - 1));
    accept    = start && (state == IDLE || state == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= Bin;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          work <= work_next;
          cnt  <= cnt + 1'b1;
          // Results are published only at the final bit; they hold otherwise.
          if (last_bit) begin
            Diff  <= work_next;
            Bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUB_SERIAL_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Operand sign bits are kept so the flag can be formed with the final result bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
      end
      if (state == RUN && last_bit) begin
        ovf_q <= (a_msb ^ b_msb) & (work_next[WIDTH-1] ^ a_msb);
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub_serial_1c.sv
// Directed self-checking bench for sub_serial_1c (WIDTH=4).
// Expected ovf follows SUB_SERIAL_OVF_EN when the bench is compiled with it.
module tb_sub_serial_1c;

  localparam int WIDTH = 4;
`ifdef SUB_SERIAL_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             busy;
  logic             done;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] last_diff = '0;
  logic             last_bout = 1'b0;
  logic             last_ovf  = 1'b0;

  sub_serial_1c #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .Diff (Diff),
    .Bout (Bout),
    .busy (busy),
    .done (done),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation in the current cycle (cycle 0) and checks cycles 1..WIDTH+2.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [WIDTH-1:0] exp_d,
                        input logic exp_b, input logic ovf_if_on,
                        input logic scramble, input string name);
    logic exp_o;
    exp_o = ovf_if_on & OVF_ON;
    A = a; B = b; Bin = bin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      if (scramble) begin
        A = ~a; B = ~b; Bin = ~bin; start = 1'b1;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0", name, i, busy, done);
      end
      checks++;
      if (Diff !== last_diff || Bout !== last_bout || ovf !== last_ovf) begin
        errors++;
        $display("FAIL %s hold cycle %0d: Diff=%h Bout=%b ovf=%b, want %h %b %b",
                 name, i, Diff, Bout, ovf, last_diff, last_bout, last_ovf);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done cycle: done=%b busy=%b, want done=1 busy=0", name, done, busy);
    end
    checks++;
    if (Diff !== exp_d || Bout !== exp_b || ovf !== exp_o) begin
      errors++;
      $display("FAIL %s result: Diff=%h Bout=%b ovf=%b, want %h %b %b",
               name, Diff, Bout, ovf, exp_d, exp_b, exp_o);
    end
    last_diff = exp_d; last_bout = exp_b; last_ovf = exp_o;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || Diff !== exp_d) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b Diff=%h, want 0 0 %h", name, done, busy, Diff, exp_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    tick();
    tick();
    checks++;
    if (Diff !== 4'h0 || Bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: Diff=%h Bout=%b busy=%b done=%b ovf=%b, want all 0", Diff, Bout, busy, done, ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: busy=%b done=%b, want 0 0", busy, done);
    end
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
  endtask

  task automatic test_basic();
    // -7 - 3 = -10 is out of signed range, so the overflow flag is set when enabled.
    run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, "basic_9_3");
  endtask

  task automatic test_borrow();
    run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, "borrow_3_9");
    run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, "borrow_0_0_bin");
  endtask

  task automatic test_overflow();
    run_op(4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, "ovf_7_8");
  endtask

  task automatic test_back_to_back();
    A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b first run cycle %0d: done=%b busy=%b, want 0 1", c, done, busy);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || Diff !== 4'h3 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b first result: done=%b Diff=%h Bout=%b, want 1 3 0", done, Diff, Bout);
    end
    // Still start=1 in the DONE cycle: a second operation (12 - 5) is accepted.
    A = 4'd12; B = 4'd5;
    tick();
    A = 4'd1; B = 4'd1; start = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || Diff !== 4'h3) begin
        errors++;
        $display("FAIL b2b second run cycle %0d: done=%b busy=%b Diff=%h, want 0 1 3", c, done, busy, Diff);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || Diff !== 4'h7 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b second result cycle 10: done=%b Diff=%h Bout=%b, want 1 7 0", done, Diff, Bout);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: done=%b busy=%b, want 0 0", done, busy);
    end
    last_diff = 4'h7; last_bout = 1'b0;
    last_ovf  = 1'b0; // 12-5: -4 - 5 = -9 would overflow
    last_ovf  = OVF_ON;
  endtask

  task automatic test_operand_change();
    run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, "operand_change");
  endtask

  task automatic test_reset_mid();
    A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy before reset: busy=%b, want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (Diff !== 4'h0 || Bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: Diff=%h Bout=%b busy=%b done=%b ovf=%b, want all 0",
               Diff, Bout, busy, done, ovf);
    end
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid no done %0d: done=%b busy=%b, want 0 0", c, done, busy);
      end
    end
    run_op(4'd4, 4'd1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, "after_reset_4_1");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
